// File: rtl/fc_argmax.sv
// Argmax stage behind the final fully-connected layer: captures N neuron outputs,
// scans them one per cycle and returns the first index holding the largest value.
module fc_argmax #(
    parameter int WIDTH = 8,
    parameter int N     = 10,
    parameter int ZW    = WIDTH * 2 + 6,
    parameter int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [ZW-1:0] z [0:N-1],
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] class_idx,
    output logic [ZW-1:0] max_val
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [IW-1:0] LAST  = IW'(N - 1);
    localparam logic [IW-1:0] FIRST = (N > 1) ? IW'(1) : '0;

    logic [1:0]    state;
    logic [IW-1:0] cnt;
    logic [IW-1:0] best_idx;
    logic [ZW-1:0] best_val;
    logic [ZW-1:0] zbuf [0:N-1];

    // NOTE: state is updated with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            best_idx <= '0;
            best_val <= '0;
            // NOTE: the capture buffer is reset too, so an aborted vector leaves no trace.
            for (int i = 0; i < N; i++) zbuf[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) zbuf[i] <= z[i];
                        best_val <= z[0];
                        best_idx <= '0;
                        cnt      <= FIRST;
                        state    <= (N == 1) ? HOLD : SCAN;
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (zbuf[cnt] > best_val) begin
                        best_val <= zbuf[cnt];
                        best_idx <= cnt;
                    end
                    if (cnt == LAST) state <= HOLD;
                    else             cnt   <= cnt + 1'b1;
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign class_idx = best_idx;
    assign max_val   = best_val;

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax: an N=10 instance for the main function and corners,
// plus an N=1 instance for the degenerate single-class build.
module tb_fc_argmax;

    localparam int ZW = 22;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [ZW-1:0] z [0:9];
    logic [3:0]    class_idx;
    logic [ZW-1:0] max_val;

    logic          in_valid1, out_ready1;
    logic          in_ready1, out_valid1;
    logic [ZW-1:0] z1 [0:0];
    logic [0:0]    class_idx1;
    logic [ZW-1:0] max_val1;

    int total = 0;
    int bad   = 0;

    fc_argmax #(.WIDTH(8), .N(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .z(z),
        .out_valid(out_valid), .out_ready(out_ready), .class_idx(class_idx), .max_val(max_val)
    );

    fc_argmax #(.WIDTH(8), .N(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .z(z1),
        .out_valid(out_valid1), .out_ready(out_ready1), .class_idx(class_idx1), .max_val(max_val1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present the current z until the handshake edge, then drop in_valid.
    task automatic accept(input string tag);
        int n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Cycles from the acceptance edge until out_valid is seen (bounded).
    task automatic wait_out(output int cycles);
        cycles = 1;
        step();
        while (!out_valid && cycles < 50) begin
            step();
            cycles++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [3:0] exp_idx, input logic [ZW-1:0] exp_val);
        int lat;
        out_ready = 1'b1;
        accept(tag);
        wait_out(lat);
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_both_high"}, 32'(in_ready & out_valid), 32'd0);
        check({tag, "_idx"}, 32'(class_idx), 32'(exp_idx));
        check({tag, "_val"}, 32'(max_val), 32'(exp_val));
        step();
        check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        z          = '{default: '0};
        z1         = '{default: '0};
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(class_idx), 32'd0);
        check("rst_val", 32'(max_val), 32'd0);
        check("rst1_in_ready", 32'(in_ready1), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        step();

        z = '{22'd5, 22'd3, 22'd900, 22'd7, 22'd0, 22'd12, 22'd899, 22'd1, 22'd2, 22'd4};
        run_vec("basic", 4'd2, 22'd900);

        z = '{default: 22'd0};
        run_vec("zeros", 4'd0, 22'd0);

        z = '{22'd10, 22'd10, 22'd10, 22'd50, 22'd10, 22'd10, 22'd10, 22'd50, 22'd10, 22'd10};
        run_vec("tie", 4'd3, 22'd50);

        z = '{default: 22'h3FFFFE};
        z[9] = 22'h3FFFFF;
        run_vec("fullscale", 4'd9, 22'h3FFFFF);

        // Backpressure: result frozen for 20 cycles while in_valid pulses are ignored.
        z = '{22'd7, 22'd7, 22'd7, 22'd7, 22'd77, 22'd7, 22'd7, 22'd7, 22'd7, 22'd7};
        out_ready = 1'b0;
        accept("bp");
        wait_out(lat);
        check("bp_latency", 32'(lat), 32'd9);
        for (int k = 0; k < 20; k++) begin
            in_valid = k[0];
            z = '{default: 22'h3FFFFF};
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_idx", 32'(class_idx), 32'd4);
            check("bp_val", 32'(max_val), 32'd77);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_done_valid", 32'(out_valid), 32'd0);
        check("bp_done_ready", 32'(in_ready), 32'd1);

        // Input isolation: z swings to large values every scan cycle.
        z = '{22'd1, 22'd2, 22'd3, 22'd4, 22'd5, 22'd6, 22'd7, 22'd8, 22'd9, 22'd10};
        accept("iso");
        lat = 1;
        for (int i = 0; i < 10; i++) z[i] = 22'h3FFFF0 + 22'(i);
        step();
        while (!out_valid && lat < 50) begin
            for (int i = 0; i < 10; i++) z[i] = 22'(($urandom % 1000) + 1000);
            step();
            lat++;
        end
        check("iso_latency", 32'(lat), 32'd9);
        check("iso_idx", 32'(class_idx), 32'd9);
        check("iso_val", 32'(max_val), 32'd10);
        step();
        check("iso_done_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a scan aborts the vector immediately.
        z = '{22'd0, 22'd0, 22'd0, 22'd999, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0};
        accept("rstscan");
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rstscan_in_ready", 32'(in_ready), 32'd1);
        check("rstscan_out_valid", 32'(out_valid), 32'd0);
        check("rstscan_idx", 32'(class_idx), 32'd0);
        check("rstscan_val", 32'(max_val), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        z = '{22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd600, 22'd5, 22'd5, 22'd5};
        run_vec("after_rst", 4'd6, 22'd600);

        // N=1 build: single-cycle latency, then back-to-back every two cycles.
        z1[0]     = 22'd123;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        check("n1_valid", 32'(out_valid1), 32'd1);
        check("n1_idx", 32'(class_idx1), 32'd0);
        check("n1_val", 32'(max_val1), 32'd123);
        step();
        check("n1_done_ready", 32'(in_ready1), 32'd1);
        in_valid1 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("n1_b2b_valid", 32'(out_valid1), 32'(k % 2));
            check("n1_b2b_ready", 32'(in_ready1), 32'((k + 1) % 2));
        end
        in_valid1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
